// File: rtl/data_storage_acc.sv
// Triggered capture buffer: records DEPTH ADC words, replays them as bytes.
// Define DSA_BUSY_OUT_EN to add the registered Busy output.
module data_storage_acc #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] DataIn,
  input  logic        FastTrigger,
  input  logic        ReadEnable,
  output logic [7:0]  DataOut,
  output logic        DataReady
`ifdef DSA_BUSY_OUT_EN
  ,
  output logic        Busy
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    LOAD,
    READOUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t state, stateNext;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ramQ;
  logic [31:0]       wordReg;
  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W-1:0] curWord;
  logic [ADDR_W-1:0] rdAddr;
  logic [1:0]        byteSel;
  logic [1:0]        nextSel;
  logic [7:0]        nextByte;
  logic              loadPhase;
  logic              wrEn;
  logic              pop;
  logic              lastPop;

  assign pop     = ReadEnable && DataReady;
  assign lastPop = pop && (byteSel == 2'd3) && (curWord == LAST);
  assign wrEn    = ((state == IDLE) && FastTrigger)
                || (state == CAPTURE);
  // Prefetch the following word so word boundaries need no bubble
  assign rdAddr  = (state == READOUT) ? curWord + ONE : '0;
  assign nextSel = byteSel + 2'd1;

  always_comb begin
    nextByte = wordReg[7:0];
    unique case (nextSel)
      2'd0: nextByte = wordReg[7:0];
      2'd1: nextByte = wordReg[15:8];
      2'd2: nextByte = wordReg[23:16];
      2'd3: nextByte = wordReg[31:24];
    endcase
  end

  always_ff @(posedge Clock) begin
    if (wrEn) mem[wrAddr] <= DataIn;
    ramQ <= mem[rdAddr];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (FastTrigger) stateNext = CAPTURE;
      CAPTURE: if (wrAddr == LAST) stateNext = LOAD;
      LOAD:    if (loadPhase) stateNext = READOUT;
      READOUT: if (lastPop) stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrAddr    <= '0;
      curWord   <= '0;
      byteSel   <= '0;
      loadPhase <= 1'b0;
      wordReg   <= '0;
      DataOut   <= '0;
      DataReady <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (FastTrigger) wrAddr <= ONE;
        end
        CAPTURE: begin
          wrAddr <= (wrAddr == LAST) ? '0 : wrAddr + ONE;
        end
        LOAD: begin
          // First cycle fetches word 0, second presents it
          loadPhase <= ~loadPhase;
          if (loadPhase) begin
            wordReg   <= ramQ;
            DataOut   <= ramQ[7:0];
            DataReady <= 1'b1;
            byteSel   <= '0;
            curWord   <= '0;
          end
        end
        READOUT: begin
          if (pop) begin
            if (byteSel != 2'd3) begin
              byteSel <= nextSel;
              DataOut <= nextByte;
            end else if (curWord == LAST) begin
              DataReady <= 1'b0;
            end else begin
              wordReg <= ramQ;
              DataOut <= ramQ[7:0];
              byteSel <= '0;
              curWord <= curWord + ONE;
            end
          end
        end
      endcase
    end
  end

`ifdef DSA_BUSY_OUT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) Busy <= 1'b0;
    else       Busy <= (stateNext != IDLE);
  end
`endif

endmodule

// File: tb/tb_data_storage_acc.sv
// Directed bench for data_storage_acc: ramp, byte order, throttling,
// trigger lockout, reset mid-readout and idle pops.
module tb_data_storage_acc;

  localparam int DEPTH  = 64;
  localparam int NBYTES = 4 * DEPTH;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] DataIn;
  logic        FastTrigger;
  logic        ReadEnable;
  logic [7:0]  DataOut;
  logic        DataReady;
`ifdef DSA_BUSY_OUT_EN
  logic        Busy;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] c;

  data_storage_acc #(.DEPTH(DEPTH), .ADDR_W(6)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .DataIn(DataIn),
    .FastTrigger(FastTrigger),
    .ReadEnable(ReadEnable),
    .DataOut(DataOut),
    .DataReady(DataReady)
`ifdef DSA_BUSY_OUT_EN
    ,
    .Busy(Busy)
`endif
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] expByte(input int mode, input int idx);
    logic [7:0] b;
    if (mode == 0) begin
      b = 8'(idx / 4);
    end else begin
      case (idx % 4)
        0: b = 8'h11;
        1: b = 8'h22;
        2: b = 8'h33;
        default: b = 8'h44;
      endcase
    end
    return b;
  endfunction

  // mode 0: ramp {c,c,c,c}; mode 1: constant 44332211
  task automatic capture(input int mode, input bit lockout);
    int n;
    bit seen;
    @(negedge Clock);
    c = 8'd0;
    FastTrigger = 1'b1;
    DataIn = (mode == 0) ? {4{c}} : 32'h44332211;
    n = -1;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge Clock);
      n++;
      @(negedge Clock);
`ifdef DSA_BUSY_OUT_EN
      if (n == 0) begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_capture got=%b want=1", Busy);
        end
      end
`endif
      if (DataReady === 1'b1) begin
        seen = 1'b1;
        FastTrigger = 1'b0;
      end else begin
        c = c + 8'd1;
        FastTrigger = lockout && (n % 9 == 4);
        DataIn = (mode == 0) ? {4{c}} : 32'h44332211;
      end
    end
    checks++;
    if (!seen || n != DEPTH + 1) begin
      errors++;
      $display("FAIL ready_latency got=%0d seen=%0b want=%0d",
               n, seen, DEPTH + 1);
    end
  endtask

  task automatic readout(input int mode, input int period,
                         input bit lockout, input int stopAt);
    int idx;
    int cyc;
    bit pop;
    logic [7:0] e;
    idx = 0;
    cyc = 0;
    while (idx < stopAt && cyc < 4000) begin
      e = expByte(mode, idx);
      checks++;
      if (DataReady !== 1'b1 || DataOut !== e) begin
        errors++;
        $display("FAIL byte[%0d] got=%h rdy=%b want=%h rdy=1",
                 idx, DataOut, DataReady, e);
      end
      pop = (cyc % period) == (period - 1);
      ReadEnable = pop;
      FastTrigger = lockout &&
                    (pop ? (idx == NBYTES - 1) : (cyc % 5 == 2));
      if (pop) idx++;
      @(negedge Clock);
      cyc++;
    end
    ReadEnable = 1'b0;
    FastTrigger = 1'b0;
    checks++;
    if (idx != stopAt) begin
      errors++;
      $display("FAIL readout_count got=%0d want=%0d", idx, stopAt);
    end
  endtask

  task automatic check_end(input int mode);
    int rises;
    logic [7:0] e;
    e = expByte(mode, NBYTES - 1);
    checks++;
    if (DataReady !== 1'b0 || DataOut !== e) begin
      errors++;
      $display("FAIL end_state got=%h rdy=%b want=%h rdy=0",
               DataOut, DataReady, e);
    end
    rises = 0;
    repeat (80) begin
      @(negedge Clock);
      if (DataReady !== 1'b0) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL no_extra_record got=%0d want=0", rises);
    end
`ifdef DSA_BUSY_OUT_EN
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle got=%b want=0", Busy);
    end
`endif
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    DataIn = '0;
    FastTrigger = 1'b0;
    ReadEnable = 1'b0;
    #2;
    checks++;
    if (DataReady !== 1'b0 || DataOut !== 8'h00) begin
      errors++;
      $display("FAIL reset got=%h rdy=%b want=00 rdy=0",
               DataOut, DataReady);
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_idle_pops();
    int bad;
    bad = 0;
    ReadEnable = 1'b1;
    repeat (50) begin
      @(negedge Clock);
      if (DataReady !== 1'b0 || DataOut !== 8'h00) bad++;
`ifdef DSA_BUSY_OUT_EN
      if (Busy !== 1'b0) bad++;
`endif
    end
    ReadEnable = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_pops got=%0d bad cycles want=0", bad);
    end
  endtask

  task automatic test_ramp();
    capture(0, 1'b0);
    readout(0, 1, 1'b0, NBYTES);
    check_end(0);
  endtask

  task automatic test_byte_order();
    capture(1, 1'b0);
    readout(1, 1, 1'b0, NBYTES);
    check_end(1);
  endtask

  task automatic test_throttled();
    capture(0, 1'b0);
    readout(0, 4, 1'b0, NBYTES);
    check_end(0);
  endtask

  task automatic test_lockout();
    capture(0, 1'b1);
    readout(0, 2, 1'b1, NBYTES);
    check_end(0);
    capture(1, 1'b0);
    readout(1, 1, 1'b0, NBYTES);
    check_end(1);
  endtask

  task automatic test_reset_mid();
    int bad;
    capture(0, 1'b0);
    readout(0, 1, 1'b0, 100);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (DataReady !== 1'b0 || DataOut !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%h rdy=%b want=00 rdy=0",
               DataOut, DataReady);
    end
    @(negedge Clock);
    Reset = 1'b0;
    bad = 0;
    ReadEnable = 1'b1;
    repeat (10) begin
      @(negedge Clock);
      if (DataReady !== 1'b0 || DataOut !== 8'h00) bad++;
    end
    ReadEnable = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_pops got=%0d want=0", bad);
    end
    capture(0, 1'b0);
    readout(0, 1, 1'b0, NBYTES);
    check_end(0);
  endtask

  initial begin
    test_reset();
    test_idle_pops();
    test_ramp();
    test_byte_order();
    test_throttled();
    test_lockout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_storage_acc.md
Name:
data_storage_acc

Overview:
- Triggered single-clock capture buffer in the ADC acquisition path.
- On a FastTrigger pulse it stores DEPTH consecutive 32-bit ADC words (four 8-bit samples per clock) into internal RAM.
- It then presents the captured data as an 8-bit byte stream, with a ready/strobe handshake, to the UART transmit wrapper (TxDWrapper).
- New triggers are ignored until the whole record has been read out.

Parameters:
- DEPTH, 64, number of 32-bit words captured per trigger; power of two, 4..4096.
- ADDR_W, 6, word address width; must equal log2(DEPTH).

Ports:
- Clock  input  1  sole clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- DataIn  input  32  four ADC samples per clock; DataIn[7:0] is the earliest sample, DataIn[31:24] the latest.
- FastTrigger  input  1  capture start request, sampled on rising edge.
- ReadEnable  input  1  consumer strobe; pops the current byte.
- DataOut  output  8  current byte of the record (first-word-fall-through).
- DataReady  output  1  high while an unread byte is valid on DataOut.

Behaviour:
- Reset (async, active-high): state=IDLE, DataReady=0, DataOut=8'h00, write and read pointers=0. Reset may occur mid-capture or mid-readout; any partial record is discarded.
- FSM states: IDLE, CAPTURE, LOAD, READOUT.
- IDLE:
  - FastTrigger=1 at edge T: DataIn at T is written as word 0; state goes to CAPTURE with the write address at 1.
  - FastTrigger=0: nothing is written.
- CAPTURE:
  - Every edge writes DataIn to the next word, with no gaps.
  - Word k holds DataIn sampled at edge T+k.
  - After word DEPTH-1 is written (edge T+DEPTH-1), state goes to LOAD.
  - FastTrigger is ignored.
- LOAD: one cycle for the RAM read of word 0. At edge T+DEPTH+1, DataOut=byte 0 of word 0, DataReady=1, state goes to READOUT.
- READOUT:
  - Byte order within a word is DataIn[7:0], [15:8], [23:16], [31:24]. Words are read in order 0..DEPTH-1, giving 4*DEPTH bytes in total.
  - DataOut holds steady until popped.
  - ReadEnable=1 at an edge pops the current byte; the next byte is on DataOut after that same edge, with no bubble, including across word boundaries. Consecutive-cycle pops are legal.
  - Popping the last byte (byte 3 of word DEPTH-1): DataReady=0 after that edge, state goes to IDLE, DataOut holds the last byte.
- ReadEnable while DataReady=0 is ignored; there is no underflow and no pointer movement.
- FastTrigger in CAPTURE, LOAD or READOUT is ignored and not queued. FastTrigger in the same cycle as the final pop is also ignored; the next trigger is accepted from IDLE.
- Pointers never wrap within a record. The RAM is 32 x DEPTH, single clock, synchronous read, and inferable as block RAM.

Optional Feature:
- Macro DSA_BUSY_OUT_EN.
- Defined: adds output port Busy (1 bit). Busy is 1 in CAPTURE, LOAD and READOUT, 0 in IDLE and during reset. It is registered and changes on the same edges as the state.
- Undefined: no Busy port; all other behaviour is identical.

Test Plan:
- Ramp capture, DEPTH=64:
  - Stimulus: 8-bit counter c incremented each clock, cleared to 0 on the trigger cycle; DataIn={c,c,c,c}; ReadEnable tied to DataReady.
  - Response: DataReady rises exactly 65 clocks after the trigger edge; 256 bytes read out as 0,0,0,0,1,1,1,1,...,63,63,63,63; then DataReady=0.
- Byte order:
  - Stimulus: DataIn=32'h44332211 constant, trigger once.
  - Response: stream repeats 11,22,33,44 for 64 words.
- Throttled consumer:
  - Stimulus: ReadEnable pulsed one cycle in four.
  - Response: same 256-byte sequence, no skipped or duplicated bytes; DataOut stable between pops.
- Trigger lockout:
  - Stimulus: extra FastTrigger pulses during capture and during readout.
  - Response: record content unchanged, still exactly 256 bytes; a trigger after DataReady falls starts a new record normally.
- Reset mid-readout:
  - Stimulus: assert Reset asynchronously (between edges) after 100 bytes.
  - Response: DataReady=0 and DataOut=00 immediately; ReadEnable then has no effect; the next trigger yields a fresh full record starting at word 0.
- Idle pops:
  - Stimulus: ReadEnable=1 with no trigger for 50 clocks.
  - Response: DataReady stays 0, DataOut stays 00; Busy=0 when DSA_BUSY_OUT_EN is defined.
